// File: rtl/mdr_hs.sv
// Memory data/address register pair with a req/ack handshake toward variable-latency memory.
// Optional REQ-phase timeout abort with sticky err flag is enabled by defining MDR_TIMEOUT_EN.
module mdr_hs #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_start,
    input  logic                  wr_start,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] bus_alu,
    input  logic                  mdr_alu_n,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] bus_c,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] mar_q, mar_nx;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_nx;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_nx;
    logic                  req_nx, we_nx, done_nx;

`ifdef MDR_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_nx;
    logic       err_q, err_nx;
`endif

    always_comb begin
        state_nx = state;
        mar_nx   = mar_q;
        wdata_nx = wdata_q;
        rdata_nx = rdata_q;
        req_nx   = mem_req;
        we_nx    = mem_we;
        done_nx  = 1'b0;
`ifdef MDR_TIMEOUT_EN
        cnt_nx   = cnt_q;
        // A clear is overridden below by a timeout in the same cycle.
        err_nx   = err_clr ? 1'b0 : err_q;
`endif
        case (state)
            IDLE: begin
                if (rd_start) begin
                    mar_nx   = addr_in;
                    we_nx    = 1'b0;
                    req_nx   = 1'b1;
                    state_nx = REQ;
`ifdef MDR_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end else if (wr_start) begin
                    mar_nx   = addr_in;
                    wdata_nx = bus_alu;
                    we_nx    = 1'b1;
                    req_nx   = 1'b1;
                    state_nx = REQ;
`ifdef MDR_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (!mem_we) begin
                        rdata_nx = mem_rdata;
                    end
                    req_nx   = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end
`ifdef MDR_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    req_nx   = 1'b0;
                    done_nx  = 1'b1;
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mar_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            mar_q        <= mar_nx;
            wdata_q      <= wdata_nx;
            rdata_q      <= rdata_nx;
            mem_req      <= req_nx;
            mem_we       <= we_nx;
            done         <= done_nx;
        end
    end

`ifdef MDR_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nx;
            err_q <= err_nx;
        end
    end

    assign err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = err_clr | (TIMEOUT_CYCLES == 0);
    assign err        = 1'b0;
`endif

    assign busy         = (state != IDLE);
    assign bus_c        = mdr_alu_n ? rdata_q : bus_alu;
    assign mem_addr     = mar_q;
    assign bus_data_out = wdata_q;

endmodule

// File: tb/tb_mdr_hs.sv
// Randomized self-checking bench for mdr_hs; the bench acts as the memory and
// predicts every output from transaction-level rules (start, wait count, ack).
module tb_mdr_hs;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 4;

`ifdef MDR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_start = 1'b0;
    logic          wr_start = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [DW-1:0] bus_alu = '0;
    logic          mdr_alu_n = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] bus_c;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] bus_data_out;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Reference view of the register pair, updated per completed transaction.
    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [AW-1:0] exp_addr  = '0;
    bit            exp_we    = 1'b0;
    bit            exp_err   = 1'b0;

    mdr_hs #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_start    (rd_start),
        .wr_start    (wr_start),
        .addr_in     (addr_in),
        .bus_alu     (bus_alu),
        .mdr_alu_n   (mdr_alu_n),
        .err_clr     (err_clr),
        .bus_c       (bus_c),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .bus_data_out(bus_data_out),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_err"}, err, exp_err);
    endtask

    task automatic check_bus_c();
        logic [DW-1:0] alu;
        mdr_alu_n = 1'b1;
        #1 chk("bus_c_mdr", bus_c, exp_rdata);
        alu       = DW'($urandom);
        bus_alu   = alu;
        mdr_alu_n = 1'b0;
        #1 chk("bus_c_alu", bus_c, alu);
    endtask

    // Called at a negedge with the DUT idle. ack_at: REQ cycle index (0-based)
    // in which the bench acks; clr_last raises err_clr in the final REQ cycle.
    task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input int unsigned ack_at,
                           input logic [DW-1:0] rv, input bit clr_last);
        bit          acked;
        int unsigned last;
        rd_start = rd;
        wr_start = wr;
        addr_in  = addr;
        bus_alu  = data;
        @(negedge clk);
        rd_start = 1'b0;
        wr_start = 1'b0;
        exp_addr = addr;
        exp_we   = !rd;
        if (!rd) exp_wdata = data;
        acked = !TO_EN || (ack_at < TO);
        last  = acked ? ack_at : TO - 1;
        for (int unsigned k = 0; k <= last; k++) begin
            chk("req_req", mem_req, 1);
            chk("req_we", mem_we, exp_we);
            chk("req_addr", mem_addr, exp_addr);
            chk("req_wdata", bus_data_out, exp_wdata);
            chk("req_busy", busy, 1);
            chk("req_done", done, 0);
            chk("req_err", err, exp_err);
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? rv : DW'($urandom);
            rd_start  = 1'($urandom_range(0, 1));
            wr_start  = 1'($urandom_range(0, 1));
            addr_in   = AW'($urandom);
            bus_alu   = DW'($urandom);
            err_clr   = clr_last && (k == last);
            @(negedge clk);
        end
        if (acked && rd) exp_rdata = rv;
        if (!acked) exp_err = 1'b1;
        else if (clr_last) exp_err = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_req", mem_req, 0);
        chk("done_addr", mem_addr, exp_addr);
        chk("done_err", err, exp_err);
        // Stray ack/starts during DONE must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = DW'($urandom);
        rd_start  = 1'b1;
        err_clr   = 1'b0;
        @(negedge clk);
        mem_ack  = 1'b0;
        rd_start = 1'b0;
        wr_start = 1'b0;
        check_idle("post");
        chk("post_wdata", bus_data_out, exp_wdata);
        check_bus_c();
    endtask

    task automatic reset_mid_req();
        rd_start = 1'b1;
        addr_in  = AW'($urandom_range(1, 255));
        @(negedge clk);
        rd_start = 1'b0;
        chk("rst_pre_req", mem_req, 1);
        #2 rst = 1'b1;
        #1;
        exp_rdata = '0;
        exp_wdata = '0;
        exp_addr  = '0;
        exp_err   = 1'b0;
        chk("rst_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", bus_data_out, 0);
        mdr_alu_n = 1'b1;
        #1 chk("rst_bus_c", bus_c, 0);
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_after");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_idle("reset");
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", bus_data_out, 0);
        chk("reset_we", mem_we, 0);
        mdr_alu_n = 1'b1;
        #1 chk("reset_bus_c", bus_c, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle");

        run_txn(1'b1, 1'b0, 8'h3C, 8'h00, 0, 8'hA5, 1'b0);
        run_txn(1'b0, 1'b1, 8'h10, 8'h5A, 3, 8'h00, 1'b0);
        run_txn(1'b1, 1'b1, 8'h77, 8'hC3, 2, 8'h96, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 3);
            run_txn(kind == 0 || kind >= 2, kind == 1 || kind == 2,
                    AW'($urandom), DW'($urandom), $urandom_range(0, 6),
                    DW'($urandom), 1'($urandom_range(0, 1)));
        end

`ifdef MDR_TIMEOUT_EN
        run_txn(1'b1, 1'b0, 8'h42, 8'h00, 1000, 8'h11, 1'b0);
        run_txn(1'b1, 1'b0, 8'h43, 8'h00, 1000, 8'h22, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        chk("err_clr", err, 0);
        run_txn(1'b1, 1'b0, 8'h44, 8'h00, TO, 8'h33, 1'b0);
        run_txn(1'b0, 1'b1, 8'h45, 8'h66, TO - 1, 8'h00, 1'b0);
`else
        rd_start = 1'b1;
        addr_in  = 8'h42;
        @(negedge clk);
        rd_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            chk("hang_req", mem_req, 1);
            chk("hang_err", err, 0);
            err_clr = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        err_clr = 1'b0;
        rst = 1'b1;
        #1;
        exp_rdata = '0;
        exp_wdata = '0;
        exp_addr  = '0;
        chk("hang_rst_req", mem_req, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif

        reset_mid_req();
        run_txn(1'b1, 1'b0, 8'h3C, 8'h00, 1, 8'h5E, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
